// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NREQ requesters.
// Optional macro REGWR_PRIO0_EN gives requester 0 strict priority over the round-robin set.
module reg_wr_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 8,
  parameter int unsigned NREG = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hold,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               wr_en,
  output logic [AW-1:0]      wr_addr,
  output logic [DW-1:0]      dat_in,
  output logic [2:0]         last_grant,
  output logic               addr_err
);

  logic [2:0]      r_rr_ptr;
  logic [2:0]      r_last_grant;
  logic            r_wr_en;
  logic            r_addr_err;
  logic [AW-1:0]   r_wr_addr;
  logic [DW-1:0]   r_dat_in;

  logic [NREQ-1:0] w_gnt;
  logic [2:0]      w_gnt_idx;
  logic            w_accept;
  logic            w_adv;
  logic [2:0]      w_next_ptr;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_data;
  logic            w_addr_ok;

  // Scan from r_rr_ptr with wrap; the first valid requester wins.
  always_comb begin
    int unsigned v_idx;
    v_idx     = 0;
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_accept  = 1'b0;
    w_adv     = 1'b1;
`ifdef REGWR_PRIO0_EN
    if (!hold && req_valid[0]) begin
      w_gnt[0] = 1'b1;
      w_accept = 1'b1;
      w_adv    = 1'b0;
    end
`endif
    for (int unsigned k = 0; k < NREQ; k++) begin
      v_idx = 32'(r_rr_ptr) + k;
      if (v_idx >= NREQ) v_idx = v_idx - NREQ;
`ifdef REGWR_PRIO0_EN
      if (v_idx != 0 && !hold && !w_accept && req_valid[v_idx]) begin
`else
      if (!hold && !w_accept && req_valid[v_idx]) begin
`endif
        w_gnt[v_idx] = 1'b1;
        w_gnt_idx    = 3'(v_idx);
        w_accept     = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = w_sel_addr | req_addr[i*AW +: AW];
        w_sel_data = w_sel_data | req_data[i*DW +: DW];
      end
    end
    w_addr_ok = (32'(w_sel_addr) < NREG);
    if (32'(w_gnt_idx) + 1 >= NREQ) w_next_ptr = '0;
    else                            w_next_ptr = w_gnt_idx + 3'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr     <= '0;
      r_last_grant <= '0;
      r_wr_en      <= 1'b0;
      r_addr_err   <= 1'b0;
      r_wr_addr    <= '0;
      r_dat_in     <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_accept) begin
        // Illegal addresses are consumed without issuing a write.
        r_wr_en      <= w_addr_ok;
        r_wr_addr    <= w_sel_addr;
        r_dat_in     <= w_sel_data;
        r_last_grant <= w_gnt_idx;
        if (!w_addr_ok) r_addr_err <= 1'b1;
        if (w_adv) r_rr_ptr <= w_next_ptr;
      end
    end
  end

  assign req_ready  = w_gnt;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign dat_in     = r_dat_in;
  assign last_grant = r_last_grant;
  assign addr_err   = r_addr_err;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter: expected register-stage results are queued when a
// request is driven and compared after the following clock edge.
module tb_reg_wr_arbiter;

  logic        clk;
  logic        reset;
  logic        hold;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [23:0] req_data;
  logic [2:0]  req_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [7:0]  dat_in;
  logic [2:0]  last_grant;
  logic        addr_err;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       en;
    logic [4:0] addr;
    logic [7:0] data;
    logic [2:0] lg;
    logic       err;
  } exp_t;

  exp_t sb[$];

  logic       m_en;
  logic [4:0] m_addr;
  logic [7:0] m_data;
  logic [2:0] m_lg;
  logic       m_err;

  reg_wr_arbiter #(.NREQ(3), .AW(5), .DW(8), .NREG(17)) dut (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .dat_in     (dat_in),
    .last_grant (last_grant),
    .addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [7:0] d);
    req_addr[i*5 +: 5] = a;
    req_data[i*8 +: 8] = d;
  endtask

  task automatic model_clear();
    m_en = 1'b0; m_addr = '0; m_data = '0; m_lg = '0; m_err = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle of requests, check the grant, then the registered write after the edge.
  task automatic step(input logic [2:0] v, input logic h, input logic [2:0] exp_rdy);
    exp_t e;
    int   g;
    req_valid = v;
    hold      = h;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    g = -1;
    for (int i = 0; i < 3; i++) if (exp_rdy[i]) g = i;
    if (g >= 0) begin
      m_addr = req_addr[g*5 +: 5];
      m_data = req_data[g*8 +: 8];
      m_lg   = 3'(g);
      m_en   = (m_addr < 5'd17);
      if (!m_en) m_err = 1'b1;
    end else begin
      m_en = 1'b0;
    end
    sb.push_back('{m_en, m_addr, m_data, m_lg, m_err});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("wr_en",      32'(wr_en),      32'(e.en));
    chk("wr_addr",    32'(wr_addr),    32'(e.addr));
    chk("dat_in",     32'(dat_in),     32'(e.data));
    chk("last_grant", 32'(last_grant), 32'(e.lg));
    chk("addr_err",   32'(addr_err),   32'(e.err));
  endtask

  task automatic check_reset_outputs();
    chk("rst_wr_en",      32'(wr_en),      32'd0);
    chk("rst_wr_addr",    32'(wr_addr),    32'd0);
    chk("rst_dat_in",     32'(dat_in),     32'd0);
    chk("rst_last_grant", 32'(last_grant), 32'd0);
    chk("rst_addr_err",   32'(addr_err),   32'd0);
  endtask

  task automatic set_rr_data();
    set_req(0, 5'd1, 8'h10);
    set_req(1, 5'd2, 8'h20);
    set_req(2, 5'd3, 8'h30);
  endtask

  initial begin
    reset     = 1'b1;
    hold      = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    model_clear();
    #2;
    check_reset_outputs();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

`ifndef REGWR_PRIO0_EN
    // Round-robin rotation with all three valid.
    set_rr_data();
    step(3'b111, 1'b0, 3'b001);
    step(3'b111, 1'b0, 3'b010);
    step(3'b111, 1'b0, 3'b100);
    step(3'b111, 1'b0, 3'b001);
    step(3'b111, 1'b0, 3'b010);
    step(3'b111, 1'b0, 3'b100);
    step(3'b000, 1'b0, 3'b000);
`endif

    // Single request to the accumulator entry.
    set_req(1, 5'd16, 8'hC3);
    step(3'b010, 1'b0, 3'b010);
    step(3'b000, 1'b0, 3'b000);

    // Hold freezes grants; release resumes from the saved pointer (2 here).
    set_rr_data();
    step(3'b111, 1'b1, 3'b000);
    step(3'b111, 1'b1, 3'b000);
    step(3'b111, 1'b1, 3'b000);
`ifdef REGWR_PRIO0_EN
    step(3'b111, 1'b0, 3'b001);
`else
    step(3'b111, 1'b0, 3'b100);
`endif
    step(3'b000, 1'b0, 3'b000);

    // Illegal address is consumed, sets sticky error; a later legal write still issues.
    set_req(0, 5'd20, 8'hFF);
    step(3'b001, 1'b0, 3'b001);
    set_req(2, 5'd2, 8'h77);
    step(3'b100, 1'b0, 3'b100);
    step(3'b000, 1'b0, 3'b000);

    // Same-address collision: serialized, both writes issue in grant order.
    set_req(1, 5'd9, 8'hA1);
    set_req(2, 5'd9, 8'hB2);
`ifdef REGWR_PRIO0_EN
    step(3'b110, 1'b0, 3'b010);
`else
    step(3'b110, 1'b0, 3'b010);
`endif
    step(3'b100, 1'b0, 3'b100);
    step(3'b000, 1'b0, 3'b000);

    // Reset right after acceptance clears the staged write before it reaches the file.
    set_req(1, 5'd3, 8'h5A);
    step(3'b010, 1'b0, 3'b010);
    reset     = 1'b1;
    req_valid = '0;
    #1;
    check_reset_outputs();
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_wr_en", 32'(wr_en), 32'd0);
    set_rr_data();
    step(3'b111, 1'b0, 3'b001);
    step(3'b000, 1'b0, 3'b000);

`ifdef REGWR_PRIO0_EN
    // Requester 0 dominates; once it drops, 1 and 2 alternate starting at 1.
    step(3'b111, 1'b0, 3'b001);
    step(3'b111, 1'b0, 3'b001);
    step(3'b111, 1'b0, 3'b001);
    step(3'b110, 1'b0, 3'b010);
    step(3'b110, 1'b0, 3'b100);
    step(3'b110, 1'b0, 3'b010);
    step(3'b000, 1'b0, 3'b000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
